// File: rtl/frame_receiver_if.sv
// Serial frame bus between the line driver and the frame receiver.
// Latency: n/a (signal bundle only).
// Backpressure: none; the serial line cannot be stalled.
// Signals: serIn (serial line, idle 1), port/nt (decoded header fields),
//          en (payload gate), serOut (gated payload), done (end-of-frame pulse).
// master = line driver / frame consumer, slave = frame_receiver.
interface frame_receiver_if #(
  parameter int PORT_W = 2,
  parameter int CNT_W  = 8
);
  logic              serIn;
  logic [PORT_W-1:0] port;
  logic [CNT_W-1:0]  nt;
  logic              en;
  logic              serOut;
  logic              done;

  modport master (
    output serIn,
    input  port, nt, en, serOut, done
  );

  modport slave (
    input  serIn,
    output port, nt, en, serOut, done
  );
endinterface

// File: rtl/frame_receiver.sv
// Serial frame receiver: start bit, PORT_W port bits, CNT_W length bits, then gates nt payload bits.
// Latency: port/nt valid 1+PORT_W+CNT_W cycles after the start bit; serOut is combinational from serIn.
// Backpressure: none; downstream must accept every gated payload bit as it arrives.
// Ports: clk, rst (sync, active high); bus (slave modport): serIn in; port, nt, en, serOut, done out.
module frame_receiver #(
  parameter int PORT_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  frame_receiver_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PORT,
    S_COUNT,
    S_PAYLOAD,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] PORT_LAST = CNT_W'(PORT_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [PORT_W-1:0] port_sr_q;
  logic [CNT_W-1:0]  cnt_sr_q;
  logic [CNT_W-1:0]  pay_cnt_q;
  logic [PORT_W-1:0] port_q;
  logic [CNT_W-1:0]  nt_q;

  logic              port_last;
  logic              cnt_last;
  logic [PORT_W-1:0] port_shift;
  logic [CNT_W-1:0]  cnt_shift;
  logic              en_c;
  logic              done_c;

  // MSB-first shift; cnt_shift already holds the bit being sampled, so on the
  // last count bit it is the complete length field.
  assign port_shift = (port_sr_q << 1) | PORT_W'(bus.serIn);
  assign cnt_shift  = (cnt_sr_q << 1)  | CNT_W'(bus.serIn);
  assign port_last  = (bit_cnt_q == PORT_LAST);
  assign cnt_last   = (bit_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_c    = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.serIn) state_d = S_PORT;
      end
      S_PORT: begin
        if (port_last) state_d = S_COUNT;
      end
      S_COUNT: begin
        // A zero-length frame skips PAYLOAD entirely.
        if (cnt_last) state_d = (cnt_shift != '0) ? S_PAYLOAD : S_DONE;
      end
      S_PAYLOAD: begin
        en_c = 1'b1;
        // Leaving at 1 keeps the down-counter from ever wrapping.
        if (pay_cnt_q == PAY_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      port_sr_q <= '0;
      cnt_sr_q  <= '0;
      pay_cnt_q <= '0;
      port_q    <= '0;
      nt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.serIn) bit_cnt_q <= '0;
        end
        S_PORT: begin
          port_sr_q <= port_shift;
          bit_cnt_q <= port_last ? '0 : bit_cnt_q + 1'b1;
        end
        S_COUNT: begin
          cnt_sr_q  <= cnt_shift;
          bit_cnt_q <= cnt_last ? '0 : bit_cnt_q + 1'b1;
          if (cnt_last) begin
            port_q    <= port_sr_q;
            nt_q      <= cnt_shift;
            pay_cnt_q <= cnt_shift;
          end
        end
        S_PAYLOAD: begin
          pay_cnt_q <= pay_cnt_q - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.port   = port_q;
  assign bus.nt     = nt_q;
  assign bus.en     = en_c;
  assign bus.done   = done_c;
  assign bus.serOut = bus.serIn & en_c;

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: reset idle, normal frame, zero length,
// maximum length, back-to-back frames and reset during payload.
// Cycle c = the clock period in which serial bit c is presented; outputs are sampled at its falling edge.
module tb_frame_receiver;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  logic sbits [0:399];

  frame_receiver_if #(.PORT_W(2), .CNT_W(8)) bus ();

  frame_receiver #(.PORT_W(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present serial bit b and reset r for one cycle, returning at the sample point.
  task automatic tick(input logic b, input logic r);
    @(posedge clk);
    #1;
    bus.serIn = b;
    rst       = r;
    @(negedge clk);
  endtask

  task automatic fill_idle();
    for (int i = 0; i < 400; i++) sbits[i] = 1'b1;
  endtask

  // Frame layout starting at off: start bit, 2 port bits, 8 count bits MSB first,
  // then payload bit i (in time order) taken from pay[i].
  task automatic load_frame(input int off, input logic [1:0] p, input logic [7:0] n,
                            input logic [254:0] pay);
    sbits[off]     = 1'b0;
    sbits[off + 1] = p[1];
    sbits[off + 2] = p[0];
    for (int i = 0; i < 8; i++) sbits[off + 3 + i] = n[7 - i];
    for (int i = 0; i < int'(n); i++) sbits[off + 11 + i] = pay[i];
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (bus.en !== 1'b0) $display("FAIL reset_en c=%0d got %b want 0", c, bus.en);
      else passed++;
      checks++;
      if (bus.done !== 1'b0) $display("FAIL reset_done c=%0d got %b want 0", c, bus.done);
      else passed++;
      checks++;
      if (bus.serOut !== 1'b0) $display("FAIL reset_serOut c=%0d got %b want 0", c, bus.serOut);
      else passed++;
      checks++;
      if (bus.port !== 2'd0) $display("FAIL reset_port c=%0d got %0d want 0", c, bus.port);
      else passed++;
      checks++;
      if (bus.nt !== 8'd0) $display("FAIL reset_nt c=%0d got %0d want 0", c, bus.nt);
      else passed++;
    end
  endtask

  // Frame 0,10,00000011,101
  task automatic test_basic_frame();
    logic e_en, e_ser, e_done;
    logic [1:0] e_port;
    logic [7:0] e_nt;
    fill_idle();
    load_frame(0, 2'd2, 8'd3, 255'b101);
    for (int c = 0; c <= 15; c++) begin
      tick(sbits[c], 1'b0);
      e_en   = (c >= 11 && c <= 13);
      e_ser  = (c == 11 || c == 13);
      e_done = (c == 14);
      e_port = (c >= 11) ? 2'd2 : 2'd0;
      e_nt   = (c >= 11) ? 8'd3 : 8'd0;
      checks++;
      if (bus.en !== e_en) $display("FAIL basic_en c=%0d got %b want %b", c, bus.en, e_en);
      else passed++;
      checks++;
      if (bus.serOut !== e_ser) $display("FAIL basic_serOut c=%0d got %b want %b", c, bus.serOut, e_ser);
      else passed++;
      checks++;
      if (bus.done !== e_done) $display("FAIL basic_done c=%0d got %b want %b", c, bus.done, e_done);
      else passed++;
      checks++;
      if (bus.port !== e_port) $display("FAIL basic_port c=%0d got %0d want %0d", c, bus.port, e_port);
      else passed++;
      checks++;
      if (bus.nt !== e_nt) $display("FAIL basic_nt c=%0d got %0d want %0d", c, bus.nt, e_nt);
      else passed++;
    end
  endtask

  // Frame 0,01,00000000 : no payload, done right after the last count bit.
  task automatic test_zero_length();
    logic e_done;
    logic [1:0] e_port;
    logic [7:0] e_nt;
    fill_idle();
    load_frame(0, 2'd1, 8'd0, 255'b0);
    for (int c = 0; c <= 12; c++) begin
      tick(sbits[c], 1'b0);
      e_done = (c == 11);
      e_port = (c >= 11) ? 2'd1 : 2'd2;
      e_nt   = (c >= 11) ? 8'd0 : 8'd3;
      checks++;
      if (bus.en !== 1'b0) $display("FAIL zero_en c=%0d got %b want 0", c, bus.en);
      else passed++;
      checks++;
      if (bus.serOut !== 1'b0) $display("FAIL zero_serOut c=%0d got %b want 0", c, bus.serOut);
      else passed++;
      checks++;
      if (bus.done !== e_done) $display("FAIL zero_done c=%0d got %b want %b", c, bus.done, e_done);
      else passed++;
      checks++;
      if (bus.port !== e_port) $display("FAIL zero_port c=%0d got %0d want %0d", c, bus.port, e_port);
      else passed++;
      checks++;
      if (bus.nt !== e_nt) $display("FAIL zero_nt c=%0d got %0d want %0d", c, bus.nt, e_nt);
      else passed++;
    end
  endtask

  // nt=255 all-ones payload: en for cycles 11..265, done in 266.
  task automatic test_max_length();
    logic e_en, e_done;
    logic [1:0] e_port;
    logic [7:0] e_nt;
    fill_idle();
    load_frame(0, 2'd3, 8'd255, {255{1'b1}});
    for (int c = 0; c <= 267; c++) begin
      tick(sbits[c], 1'b0);
      e_en   = (c >= 11 && c <= 265);
      e_done = (c == 266);
      e_port = (c >= 11) ? 2'd3 : 2'd1;
      e_nt   = (c >= 11) ? 8'd255 : 8'd0;
      checks++;
      if (bus.en !== e_en) $display("FAIL max_en c=%0d got %b want %b", c, bus.en, e_en);
      else passed++;
      checks++;
      if (bus.serOut !== e_en) $display("FAIL max_serOut c=%0d got %b want %b", c, bus.serOut, e_en);
      else passed++;
      checks++;
      if (bus.done !== e_done) $display("FAIL max_done c=%0d got %b want %b", c, bus.done, e_done);
      else passed++;
      checks++;
      if (bus.port !== e_port) $display("FAIL max_port c=%0d got %0d want %0d", c, bus.port, e_port);
      else passed++;
      checks++;
      if (bus.nt !== e_nt) $display("FAIL max_nt c=%0d got %0d want %0d", c, bus.nt, e_nt);
      else passed++;
    end
  endtask

  // nt=2 (port 1, payload 11) then nt=4 (port 2, payload 1001) starting at cycle 14.
  task automatic test_back_to_back();
    logic e_en, e_ser, e_done;
    logic [1:0] e_port;
    logic [7:0] e_nt;
    fill_idle();
    load_frame(0, 2'd1, 8'd2, 255'b11);
    load_frame(14, 2'd2, 8'd4, 255'b1001);
    for (int c = 0; c <= 30; c++) begin
      tick(sbits[c], 1'b0);
      e_en   = (c >= 11 && c <= 12) || (c >= 25 && c <= 28);
      e_ser  = (c == 11 || c == 12 || c == 25 || c == 28);
      e_done = (c == 13 || c == 29);
      e_port = (c >= 25) ? 2'd2 : (c >= 11) ? 2'd1 : 2'd3;
      e_nt   = (c >= 25) ? 8'd4 : (c >= 11) ? 8'd2 : 8'd255;
      checks++;
      if (bus.en !== e_en) $display("FAIL b2b_en c=%0d got %b want %b", c, bus.en, e_en);
      else passed++;
      checks++;
      if (bus.serOut !== e_ser) $display("FAIL b2b_serOut c=%0d got %b want %b", c, bus.serOut, e_ser);
      else passed++;
      checks++;
      if (bus.done !== e_done) $display("FAIL b2b_done c=%0d got %b want %b", c, bus.done, e_done);
      else passed++;
      checks++;
      if (bus.port !== e_port) $display("FAIL b2b_port c=%0d got %0d want %0d", c, bus.port, e_port);
      else passed++;
      checks++;
      if (bus.nt !== e_nt) $display("FAIL b2b_nt c=%0d got %0d want %0d", c, bus.nt, e_nt);
      else passed++;
    end
  endtask

  // nt=5 frame reset during its 3rd payload cycle (13), then an nt=1 frame from cycle 21.
  task automatic test_reset_mid_payload();
    logic e_en, e_ser, e_done;
    logic [1:0] e_port;
    logic [7:0] e_nt;
    fill_idle();
    load_frame(0, 2'd3, 8'd5, {255{1'b1}});
    for (int c = 14; c <= 20; c++) sbits[c] = 1'b1;
    load_frame(21, 2'd1, 8'd1, 255'b1);
    for (int c = 0; c <= 34; c++) begin
      tick(sbits[c], (c == 13) ? 1'b1 : 1'b0);
      if (c <= 13) begin
        e_en   = (c >= 11);
        e_ser  = (c >= 11);
        e_done = 1'b0;
        e_port = (c >= 11) ? 2'd3 : 2'd2;
        e_nt   = (c >= 11) ? 8'd5 : 8'd4;
      end else begin
        e_en   = (c == 32);
        e_ser  = (c == 32);
        e_done = (c == 33);
        e_port = (c >= 32) ? 2'd1 : 2'd0;
        e_nt   = (c >= 32) ? 8'd1 : 8'd0;
      end
      checks++;
      if (bus.en !== e_en) $display("FAIL rstmid_en c=%0d got %b want %b", c, bus.en, e_en);
      else passed++;
      checks++;
      if (bus.serOut !== e_ser) $display("FAIL rstmid_serOut c=%0d got %b want %b", c, bus.serOut, e_ser);
      else passed++;
      checks++;
      if (bus.done !== e_done) $display("FAIL rstmid_done c=%0d got %b want %b", c, bus.done, e_done);
      else passed++;
      checks++;
      if (bus.port !== e_port) $display("FAIL rstmid_port c=%0d got %0d want %0d", c, bus.port, e_port);
      else passed++;
      checks++;
      if (bus.nt !== e_nt) $display("FAIL rstmid_nt c=%0d got %0d want %0d", c, bus.nt, e_nt);
      else passed++;
    end
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    rst       = 1'b1;
    bus.serIn = 1'b1;
    test_reset();
    test_basic_frame();
    test_zero_length();
    test_max_length();
    test_back_to_back();
    test_reset_mid_payload();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/frame_receiver.md
# frame_receiver

Serial frame receiver that is the front end of the serial message path. It watches an idle-high serial line for a start bit, then shifts in a destination port field and an 8-bit payload length. It then gates the payload bits through to the downstream transmitter for exactly that many cycles and pulses `done` when the frame ends. Its `en`, `nt` and `serOut` outputs drive the transmitter's `en`, `nt` and `serIn` inputs directly.

## Interface
- `PORT_W`, 2: width of destination port field.
- `CNT_W`, 8: width of payload length field and of `nt`.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `serIn`  in  1  serial line; idle level 1, bits sampled once per clock, MSB first.
- `port`  out  PORT_W  destination port of the current or last frame.
- `nt`  out  CNT_W  payload length of the current or last frame.
- `en`  out  1  high exactly during the payload cycles.
- `serOut`  out  1  `serIn & en` (combinational); 0 outside payload.
- `done`  out  1  one-cycle pulse in the cycle after the last payload bit (or after the last count bit when `nt`=0).

## Operation
- FSM states: IDLE, PORT, COUNT, PAYLOAD, DONE. One state register plus one bit counter (width ≥ CNT_W), a PORT_W shift register, a CNT_W shift register and a CNT_W payload down-counter.
- IDLE:
  - `serIn`=1: stay in IDLE.
  - `serIn`=0: this is the start bit; go to PORT and clear the bit counter.
- PORT: shift `serIn` into the port shift register, MSB first, for PORT_W cycles, then go to COUNT.
- COUNT: shift `serIn` into the count shift register, MSB first, for CNT_W cycles. On the last count bit:
  - Load `port` and `nt` from the assembled fields. The `nt` value includes the bit being sampled.
  - Load the payload counter with the same value.
  - Go to PAYLOAD if the value is nonzero, otherwise go to DONE.
- PAYLOAD:
  - `en`=1.
  - Decrement the payload counter every cycle.
  - Leave to DONE in the cycle where the counter equals 1, i.e. after exactly `nt` PAYLOAD cycles.
- DONE: `done`=1 for one cycle, `serIn` is ignored, then unconditionally go to IDLE. A new start bit is recognised only in IDLE.
- `port` and `nt` hold their values from the load until the next frame's load. They do not change during PAYLOAD, DONE or the following IDLE.
- Arithmetic: `nt` is unsigned, range 0..2^CNT_W−1. The maximum payload is 255 bits. The down-counter never wraps.

## Timing
- Reset values: state IDLE, `port`=0, `nt`=0, `en`=0, `serOut`=0, `done`=0, all internal counters and registers 0.
- Frame timeline, with the start bit sampled in cycle 0 and the default parameters:
  - cycles 1–2: port bits.
  - cycles 3–10: count bits.
  - from cycle 11: `port` and `nt` valid.
  - cycles 11..10+nt: `en`=1.
  - cycle 11+nt: `done`=1.
  - cycle 12+nt: back in IDLE.
- `nt`=0: no `en` cycle; `done` in cycle 11.
- Minimum frame spacing: the next start bit may be sampled in cycle 12+nt.
- `rst` asserted in any state, including mid-PAYLOAD: at the next edge the block is in IDLE with all outputs at reset values. `en` and `done` drop in that same cycle, and no `done` is produced for the aborted frame.
- `serOut` follows `serIn` combinationally while `en`=1. There is no added latency.

## Test plan
- Reset, then `serIn`=1 for 20 cycles -> stays IDLE; `en`, `done`, `serOut`, `port`, `nt` all 0 throughout.
- Frame 0,10,00000011,101 starting at cycle 0 -> `port`=2 and `nt`=3 from cycle 11; `en`=1 in cycles 11–13 with `serOut`=1,0,1; `done`=1 only in cycle 14.
- Frame 0,01,00000000 -> `port`=1, `nt`=0 from cycle 11; `en` never asserted; `done`=1 in cycle 11.
- Frame with `nt`=255 of all-ones payload -> `en`=1 for exactly 255 cycles, `serOut`=1 throughout; `done` in cycle 266; no wrap.
- Two back-to-back frames (`nt`=2 then `nt`=4), second start bit in cycle 14 -> both frames decoded; first `done` in cycle 13; second `nt`=4 valid from cycle 25; `nt` holds 2 until then.
- `rst` pulse in the 3rd payload cycle of an `nt`=5 frame -> next cycle: `en`=0, `nt`=0, `port`=0, no `done`; a following frame decodes normally.
